// File: rtl/stream_pkg.sv
// rtl/stream_pkg.sv - shared helpers for the stream width converters
//
// Purpose: width helpers and a lane-reversal function shared by the stream
// width downsizer and the planned upsizer.
// Contents:
//   LANE_MAX_BITS  widest word lane_reverse can handle
//   clog2_plus1()  bits needed to hold the value n (i.e. $clog2(n+1))
//   lane_reverse() swap lane order of a word made of 'lanes' lanes of 'bits'
package stream_pkg;

   // Upper bound on Ratio*DataBits for lane_reverse; callers zero-extend
   // into this width and truncate the result back with a cast.
   localparam int LANE_MAX_BITS = 1024;

   // Number of bits needed to represent the value n (n >= 0).
   function automatic int clog2_plus1(input int n);
      int w;
      w = 1;
      while ((1 << w) <= n) begin
         w = w + 1;
      end
      return w;
   endfunction

   // Reverse lane order: lane k of the input lands in lane (lanes-1-k).
   // Bits above lanes*bits are returned as zero.
   function automatic logic [LANE_MAX_BITS-1:0] lane_reverse(
      input logic [LANE_MAX_BITS-1:0] data,
      input int                       lanes,
      input int                       bits
   );
      logic [LANE_MAX_BITS-1:0] r;
      int                       lane;
      int                       pos;
      r = '0;
      for (int i = 0; i < LANE_MAX_BITS; i++) begin
         if (i < lanes * bits) begin
            lane = i / bits;
            pos  = i % bits;
            r[(lanes - 1 - lane) * bits + pos] = data[i];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/stream_width_downsizer.sv
// rtl/stream_width_downsizer.sv - split wide words into 1..Ratio narrow beats
//
// Purpose: accepts one Ratio*DataBits word, then emits in_count lanes of
// DataBits from a registered holding/shift register (no in->out comb path
// on data). A new word may load in the same cycle the last lane is taken.
// Ratio must be at least 2.
//
// Optional feature: define STREAM_DOWNSIZER_LAST_EN to add in_last/out_last;
// out_last marks the final emitted lane of a word captured with in_last=1.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   wide word handshake
//   in_data             wide word, lane 0 in the LSBs
//   in_count            lanes to emit: 0 means Ratio, >Ratio saturates
//   out_valid/out_ready narrow lane handshake
//   out_data            current lane
//   busy                holding register occupied (same as out_valid)
//   in_last/out_last    only with STREAM_DOWNSIZER_LAST_EN
module stream_width_downsizer
   import stream_pkg::*;
#(
   parameter int DataBits  = 8,
   parameter int Ratio     = 4,
   parameter int MsbFirst  = 0,
   parameter int CountBits = clog2_plus1(Ratio)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [Ratio*DataBits-1:0] in_data,
   input  logic [CountBits-1:0]      in_count,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [DataBits-1:0]       out_data,
   output logic                      busy
`ifdef STREAM_DOWNSIZER_LAST_EN
   ,
   input  logic                      in_last,
   output logic                      out_last
`endif
);

   localparam int                   WordBits   = Ratio * DataBits;
   localparam logic [CountBits-1:0] RatioCount = CountBits'(Ratio);
   localparam logic [CountBits-1:0] OneCount   = CountBits'(1);

   logic [WordBits-1:0]  data_q, data_d;
   logic [CountBits-1:0] remaining_q, remaining_d;
   logic                 valid_q, valid_d;

   logic                 load;
   logic                 consume;
   logic                 last_lane;
   logic [WordBits-1:0]  load_data;
   logic [CountBits-1:0] load_count;

   assign last_lane = (remaining_q == OneCount);

   // Ready when empty, or when the lane being handed off right now is the
   // last one: that is what gives back-to-back words without a bubble.
   assign in_ready = !valid_q | (out_ready & last_lane);
   assign load     = in_valid & in_ready;
   assign consume  = valid_q & out_ready;

   // 0 and anything above Ratio both mean a full word.
   always_comb begin
      load_count = RatioCount;
      if ((in_count != '0) && (in_count < RatioCount)) begin
         load_count = in_count;
      end
   end

   // MSB-first words are lane-reversed on capture so emission always
   // shifts right and takes the bottom lane.
   always_comb begin
      load_data = in_data;
      if (MsbFirst != 0) begin
         load_data = WordBits'(lane_reverse(LANE_MAX_BITS'(in_data), Ratio, DataBits));
      end
   end

   always_comb begin
      data_d      = data_q;
      remaining_d = remaining_q;
      valid_d     = valid_q;
      if (load) begin
         // Load takes priority over a simultaneous last-lane consume.
         data_d      = load_data;
         remaining_d = load_count;
         valid_d     = 1'b1;
      end else if (consume) begin
         data_d      = data_q >> DataBits;
         remaining_d = remaining_q - OneCount;
         valid_d     = !last_lane;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q      <= '0;
         remaining_q <= '0;
         valid_q     <= 1'b0;
      end else begin
         data_q      <= data_d;
         remaining_q <= remaining_d;
         valid_q     <= valid_d;
      end
   end

   assign out_valid = valid_q;
   assign busy      = valid_q;
   assign out_data  = data_q[DataBits-1:0];

`ifdef STREAM_DOWNSIZER_LAST_EN
   logic last_q, last_d;

   always_comb begin
      last_d = last_q;
      if (load) begin
         last_d = in_last;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= 1'b0;
      end else begin
         last_q <= last_d;
      end
   end

   assign out_last = valid_q & last_q & last_lane;
`endif

endmodule

// File: tb/tb_stream_width_downsizer.sv
// tb/tb_stream_width_downsizer.sv - self-checking bench for stream_width_downsizer
module tb_stream_width_downsizer;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] in_data;
   logic [2:0]  in_count;
   logic        in_last;
   logic        out_ready;

   logic        in_ready_a, out_valid_a, busy_a;
   logic [7:0]  out_data_a;
   logic        in_ready_b, out_valid_b, busy_b;
   logic [7:0]  out_data_b;
`ifdef STREAM_DOWNSIZER_LAST_EN
   logic        out_last_a, out_last_b;
`endif

   int errors = 0;
   int checks = 0;
   bit rand_ready = 0;

   typedef struct {
      logic [7:0] data;
      logic       last;
   } lane_t;

   lane_t exp_a[$];
   lane_t exp_b[$];

   stream_width_downsizer #(.DataBits(8), .Ratio(4), .MsbFirst(0)) u_dut_lsb (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready_a),
      .in_data   (in_data),
      .in_count  (in_count),
      .out_valid (out_valid_a),
      .out_ready (out_ready),
      .out_data  (out_data_a),
      .busy      (busy_a)
`ifdef STREAM_DOWNSIZER_LAST_EN
      ,
      .in_last   (in_last),
      .out_last  (out_last_a)
`endif
   );

   stream_width_downsizer #(.DataBits(8), .Ratio(4), .MsbFirst(1)) u_dut_msb (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready_b),
      .in_data   (in_data),
      .in_count  (in_count),
      .out_valid (out_valid_b),
      .out_ready (out_ready),
      .out_data  (out_data_b),
      .busy      (busy_b)
`ifdef STREAM_DOWNSIZER_LAST_EN
      ,
      .in_last   (in_last),
      .out_last  (out_last_b)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: a word yields n lanes, n = count (0 or >4 means 4), taken
   // from the low lane upward (LSB-first) or from the high lane downward.
   function automatic void push_word(input logic [31:0] d, input logic [2:0] c, input logic l);
      int    n;
      lane_t e;
      n = (c == 0 || c > 4) ? 4 : int'(c);
      for (int i = 0; i < n; i++) begin
         e.last = l && (i == n - 1);
         e.data = d[i*8 +: 8];
         exp_a.push_back(e);
         e.data = d[(3-i)*8 +: 8];
         exp_b.push_back(e);
      end
   endfunction

   // Scoreboard and protocol monitor, sampled on the falling edge.
   initial begin : monitor
      bit         stall_a, stall_b;
      logic [7:0] held_a, held_b;
      lane_t      e;
      stall_a = 0;
      stall_b = 0;
      held_a  = '0;
      held_b  = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            exp_a.delete();
            exp_b.delete();
            stall_a = 0;
            stall_b = 0;
         end else begin
            if (stall_a) begin
               check("hold_valid_a", out_valid_a, 1);
               check("hold_data_a", out_data_a, held_a);
            end
            if (stall_b) begin
               check("hold_valid_b", out_valid_b, 1);
               check("hold_data_b", out_data_b, held_b);
            end
            check("busy_a", busy_a, out_valid_a);
            check("busy_b", busy_b, out_valid_b);
            check("in_ready_match", in_ready_a, in_ready_b);
            if (out_valid_a && out_ready) begin
               check("lane_expected_a", exp_a.size() != 0, 1);
               if (exp_a.size() != 0) begin
                  e = exp_a.pop_front();
                  check("lane_data_a", out_data_a, e.data);
`ifdef STREAM_DOWNSIZER_LAST_EN
                  check("lane_last_a", out_last_a, e.last);
`endif
               end
            end
            if (out_valid_b && out_ready) begin
               check("lane_expected_b", exp_b.size() != 0, 1);
               if (exp_b.size() != 0) begin
                  e = exp_b.pop_front();
                  check("lane_data_b", out_data_b, e.data);
`ifdef STREAM_DOWNSIZER_LAST_EN
                  check("lane_last_b", out_last_b, e.last);
`endif
               end
            end
            stall_a = out_valid_a && !out_ready;
            stall_b = out_valid_b && !out_ready;
            held_a  = out_data_a;
            held_b  = out_data_b;
            if (in_valid && in_ready_a) begin
               push_word(in_data, in_count, in_last);
            end
         end
      end
   end

   // Presents a word and returns 1ns after the accepting edge.
   task automatic send_word(input logic [31:0] d, input logic [2:0] c, input logic l);
      bit accepted;
      accepted = 0;
      in_data  = d;
      in_count = c;
      in_last  = l;
      in_valid = 1'b1;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (in_ready_a) begin
            accepted = 1;
            break;
         end
         @(posedge clk);
         #1;
         if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      end
      check("send_accepted", accepted, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      logic [7:0]  lsb_seq[4];
      logic [7:0]  msb_seq[4];
      logic [7:0]  nb_a[6];
      logic [7:0]  nb_b[6];
      bit          pat[6];
      logic [31:0] w;
      int          li;
      bit          drained;

      lsb_seq = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
      msb_seq = '{8'hDD, 8'hCC, 8'hBB, 8'hAA};
      nb_a    = '{8'h11, 8'h22, 8'h55, 8'h66, 8'h77, 8'h88};
      nb_b    = '{8'h44, 8'h33, 8'h88, 8'h77, 8'h66, 8'h55};
      pat     = '{1, 0, 0, 1, 1, 1};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_count  = '0;
      in_last   = 1'b0;
      out_ready = 1'b1;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid_a", out_valid_a, 0);
      check("rst_out_valid_b", out_valid_b, 0);
      check("rst_out_data_a", out_data_a, 0);
      check("rst_in_ready_a", in_ready_a, 1);
      check("rst_busy_a", busy_a, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Full word, count 0 means Ratio
      send_word(32'hDDCCBBAA, 3'd0, 1'b0);
      for (int k = 0; k < 4; k++) begin
         check("full_valid", out_valid_a, 1);
         check("full_data_a", out_data_a, lsb_seq[k]);
         check("full_data_b", out_data_b, msb_seq[k]);
         check("full_in_ready", in_ready_a, k == 3);
         @(posedge clk);
         #1;
      end
      check("full_idle", out_valid_a, 0);

      // Partial word followed by a full word with no bubble
      send_word(32'h44332211, 3'd2, 1'b0);
      in_data  = 32'h88776655;
      in_count = 3'd4;
      in_valid = 1'b1;
      for (int k = 0; k < 6; k++) begin
         check("nobubble_valid", out_valid_a, 1);
         check("nobubble_data_a", out_data_a, nb_a[k]);
         check("nobubble_data_b", out_data_b, nb_b[k]);
         check("nobubble_in_ready", in_ready_a, (k == 1) || (k == 5));
         @(posedge clk);
         #1;
         if (k == 1) in_valid = 1'b0;
      end
      check("nobubble_idle", out_valid_a, 0);

      // Backpressure 1,0,0,1,1,1 over one full word
      w = $urandom;
      send_word(w, 3'd4, 1'b0);
      li = 0;
      for (int k = 0; k < 6; k++) begin
         out_ready = pat[k];
         check("bp_valid", out_valid_a, 1);
         check("bp_data_a", out_data_a, w[li*8 +: 8]);
         check("bp_data_b", out_data_b, w[(3-li)*8 +: 8]);
         check("bp_in_ready", in_ready_a, pat[k] && (li == 3));
         @(posedge clk);
         #1;
         if (pat[k]) li++;
      end
      check("bp_lane_count", li, 4);
      check("bp_idle", out_valid_a, 0);
      out_ready = 1'b1;

      // Reset asserted after lane BB has been taken
      send_word(32'hDDCCBBAA, 3'd0, 1'b0);
      @(posedge clk);
      #1;
      check("rstmid_bb", out_data_a, 8'hBB);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("rstmid_valid_a", out_valid_a, 0);
      check("rstmid_valid_b", out_valid_b, 0);
      check("rstmid_data_a", out_data_a, 0);
      check("rstmid_in_ready", in_ready_a, 1);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         #1;
         check("rstmid_no_output", out_valid_a | out_valid_b, 0);
         check("rstmid_ready_after", in_ready_a, 1);
      end

`ifdef STREAM_DOWNSIZER_LAST_EN
      // out_last only on the final lane of a word with in_last
      send_word($urandom, 3'd3, 1'b1);
      for (int k = 0; k < 3; k++) begin
         check("last_pulse_a", out_last_a, k == 2);
         check("last_pulse_b", out_last_b, k == 2);
         @(posedge clk);
         #1;
      end
      send_word($urandom, 3'd4, 1'b0);
      for (int k = 0; k < 4; k++) begin
         check("last_never", out_last_a | out_last_b, 0);
         @(posedge clk);
         #1;
      end
`endif

      // Random words, random counts (including 0 and >Ratio), random ready
      rand_ready = 1;
      for (int n = 0; n < 40; n++) begin
         send_word($urandom, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      end
      drained = 0;
      for (int i = 0; i < 400; i++) begin
         @(posedge clk);
         #1;
         out_ready = 1'($urandom_range(0, 1));
         if (exp_a.size() == 0 && exp_b.size() == 0 && !out_valid_a && !out_valid_b) begin
            drained = 1;
            break;
         end
      end
      rand_ready = 0;
      out_ready  = 1'b1;
      check("random_drained", drained, 1);
      check("random_queue_a_empty", exp_a.size(), 0);
      check("random_queue_b_empty", exp_b.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
